// File: rtl/switch_matrix_cfg_loader.sv
// ---------------------------------------------------------------------------
// switch_matrix_cfg_loader
//
// Loads a framed stream of routing words for a switch-matrix tile. A frame
// has N = 2*NTB + 2*NLR words followed by one checksum word, which is the XOR
// of those N words. All N words are validated and collected in a shadow
// buffer. Only a clean frame with a matching checksum is copied to cfg_out,
// and the copy happens in one step. A rejected frame leaves cfg_out
// unchanged, so the tile is never partially routed.
//
// Word layout (CW = 6): [2:0] source side, [5:3] source index.
//   side 0 = undriven (the index is ignored), 1 = top, 2 = right,
//   3 = bottom, 4 = left, 5..7 = illegal.
//
// Entry order on cfg_out (entry k sits at [k*CW +: CW]):
//   top[0..NTB-1], bottom[0..NTB-1], left[0..NLR-1], right[0..NLR-1]
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      pulse; opens a new frame (also aborts a frame in progress)
//   clear      pulse; zeroes cfg_out while idle
//   cfg_valid  word valid
//   cfg_data   routing word or checksum word
//   cfg_ready  loader can accept a word
//   cfg_out    active configuration bus
//   busy       frame in progress
//   done       one-cycle pulse on a successful commit
//   err        sticky flag for a rejected frame, cleared by the next start
//   err_code   0 none, 1 illegal field, 2 checksum mismatch, 3 self-loop
//   dbg_state  current FSM state, for observation only
//
// Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready
// are both high. cfg_ready is a register that depends only on the state, and
// never on cfg_valid. It stays high for the whole LOAD/CHECK phase, so the
// loader can take one word per cycle. A cfg_valid while cfg_ready is low is
// ignored.
// ---------------------------------------------------------------------------
module switch_matrix_cfg_loader #(
    parameter int NTB = 5,
    parameter int NLR = 4,
    parameter int CW  = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             clear,
    input  logic                             cfg_valid,
    input  logic [CW-1:0]                    cfg_data,
    output logic                             cfg_ready,
    output logic [(2*NTB+2*NLR)*CW-1:0]      cfg_out,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [1:0]                       err_code,
    output logic [2:0]                       dbg_state
);

    localparam int N    = 2*NTB + 2*NLR;
    localparam int CNTW = $clog2(N + 1);

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_ILLEGAL  = 2'd1;
    localparam logic [1:0] CODE_CHECKSUM = 2'd2;
    localparam logic [1:0] CODE_LOOP     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t             state;
    logic [CNTW-1:0]    cnt;
    logic [CW-1:0]      acc;
    logic [1:0]         rec_code;
    logic [CW-1:0]      shadow [N];
    logic [N*CW-1:0]    shadow_flat;

    logic               xfer;
    logic [2:0]         w_side;
    logic [2:0]         w_idx;
    logic [2:0]         own_side;
    logic [2:0]         own_idx;
    logic [1:0]         w_code;

    assign dbg_state = state;
    assign xfer      = cfg_valid && cfg_ready;

    // Flatten the shadow buffer so that a commit is a single wide copy.
    always_comb begin
        shadow_flat = '0;
        for (int k = 0; k < N; k++) begin
            shadow_flat[k*CW +: CW] = shadow[k];
        end
    end

    // Side and index of the pin that the current entry (cnt) configures.
    // The self-loop check compares the incoming word against these.
    always_comb begin
        own_side = SIDE_NONE;
        own_idx  = 3'd0;
        if (int'(cnt) < NTB) begin
            own_side = SIDE_TOP;
            own_idx  = 3'(int'(cnt));
        end else if (int'(cnt) < 2*NTB) begin
            own_side = SIDE_BOTTOM;
            own_idx  = 3'(int'(cnt) - NTB);
        end else if (int'(cnt) < 2*NTB + NLR) begin
            own_side = SIDE_LEFT;
            own_idx  = 3'(int'(cnt) - 2*NTB);
        end else begin
            own_side = SIDE_RIGHT;
            own_idx  = 3'(int'(cnt) - 2*NTB - NLR);
        end
    end

    // Classify the word on cfg_data for the current entry. An undriven
    // source is always legal. The range checks come before the self-loop
    // check, although an out-of-range word can never match an own pin anyway.
    always_comb begin
        w_side = cfg_data[2:0];
        w_idx  = cfg_data[5:3];
        w_code = CODE_NONE;
        case (w_side)
            SIDE_NONE: w_code = CODE_NONE;
            SIDE_TOP, SIDE_BOTTOM: begin
                if (int'(w_idx) >= NTB) begin
                    w_code = CODE_ILLEGAL;
                end
            end
            SIDE_LEFT, SIDE_RIGHT: begin
                if (int'(w_idx) >= NLR) begin
                    w_code = CODE_ILLEGAL;
                end
            end
            default: w_code = CODE_ILLEGAL;
        endcase
        if (w_code == CODE_NONE && w_side != SIDE_NONE &&
            w_side == own_side && w_idx == own_idx) begin
            w_code = CODE_LOOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cfg_out   <= '0;
            for (int k = 0; k < N; k++) begin
                shadow[k] <= '0;
            end
            cnt       <= '0;
            acc       <= '0;
            rec_code  <= CODE_NONE;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= CODE_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start has priority over clear when both arrive together.
                    if (start) begin
                        state     <= S_LOAD;
                        cnt       <= '0;
                        acc       <= '0;
                        rec_code  <= CODE_NONE;
                        err       <= 1'b0;
                        err_code  <= CODE_NONE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end else if (clear) begin
                        cfg_out <= '0;
                    end
                end

                S_LOAD: begin
                    if (start) begin
                        // Abort and restart the frame. The stale shadow
                        // entries are overwritten before any later commit.
                        cnt      <= '0;
                        acc      <= '0;
                        rec_code <= CODE_NONE;
                    end else if (xfer) begin
                        shadow[cnt] <= cfg_data;
                        acc         <= acc ^ cfg_data;
                        cnt         <= cnt + 1'b1;
                        // The first error of the frame wins.
                        if (rec_code == CODE_NONE) begin
                            rec_code <= w_code;
                        end
                        if (cnt == CNTW'(N - 1)) begin
                            state <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (start) begin
                        state    <= S_LOAD;
                        cnt      <= '0;
                        acc      <= '0;
                        rec_code <= CODE_NONE;
                    end else if (xfer) begin
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                        if (rec_code == CODE_NONE && cfg_data == acc) begin
                            // cfg_out and done are registered on the same
                            // edge, so both are visible in the commit cycle.
                            state   <= S_COMMIT;
                            cfg_out <= shadow_flat;
                            done    <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= (rec_code != CODE_NONE) ? rec_code
                                                                : CODE_CHECKSUM;
                        end
                    end
                end

                S_COMMIT: begin
                    state <= S_IDLE;
                end

                S_ERROR: begin
                    state <= S_IDLE;
                end

                default: begin
                    state     <= S_IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_matrix_cfg_loader.sv
// ---------------------------------------------------------------------------
// Testbench for switch_matrix_cfg_loader.
// A frame-level reference model collects the words of each frame. When the
// frame is complete it judges the whole frame at once, working from the
// word-decoding rules, and keeps the expected outputs. A negedge compare
// process checks every DUT output against the model on every cycle. Directed
// scenarios add literal expectations for latency and error codes. Randomized
// frames with stalls come after them.
// ---------------------------------------------------------------------------
module tb_switch_matrix_cfg_loader;

    localparam int NTB = 5;
    localparam int NLR = 4;
    localparam int CW  = 6;
    localparam int N   = 2*NTB + 2*NLR;

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             rst;
    logic             start;
    logic             clear;
    logic             cfg_valid;
    logic [CW-1:0]    cfg_data;
    logic             cfg_ready;
    logic [N*CW-1:0]  cfg_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [2:0]       dbg_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    switch_matrix_cfg_loader #(.NTB(NTB), .NLR(NLR), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_out   (cfg_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_count = 0;
    int last_done_cyc = -1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 receiving words, 2 commit cycle, 3 reject cycle
    int               m_phase;
    logic [CW-1:0]    m_words[$];
    logic [N*CW-1:0]  m_cfg;
    logic             m_done;
    logic             m_err;
    logic [1:0]       m_code;

    function automatic int own_side(input int k);
        if (k < NTB)             return 1;
        if (k < 2*NTB)           return 3;
        if (k < 2*NTB + NLR)     return 4;
        return 2;
    endfunction

    function automatic int own_idx(input int k);
        if (k < NTB)             return k;
        if (k < 2*NTB)           return k - NTB;
        if (k < 2*NTB + NLR)     return k - 2*NTB;
        return k - 2*NTB - NLR;
    endfunction

    function automatic int word_code(input logic [CW-1:0] w, input int k);
        int side;
        int idx;
        int lim;
        side = int'(w[2:0]);
        idx  = int'(w[5:3]);
        if (side == 0) return 0;
        if (side > 4)  return 1;
        lim = (side == 1 || side == 3) ? NTB : NLR;
        if (idx >= lim) return 1;
        if (side == own_side(k) && idx == own_idx(k)) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_words.delete();
        m_cfg   = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_code  = 2'd0;
    endtask

    task automatic model_judge();
        int code;
        logic [CW-1:0] x;
        logic [N*CW-1:0] packed_v;
        code = 0;
        x = '0;
        packed_v = '0;
        for (int k = 0; k < N; k++) begin
            if (code == 0) code = word_code(m_words[k], k);
            x = x ^ m_words[k];
            packed_v[k*CW +: CW] = m_words[k];
        end
        if (code == 0 && m_words[N] == x) begin
            m_phase = 2;
            m_done  = 1'b1;
            m_cfg   = packed_v;
        end else begin
            m_phase = 3;
            m_err   = 1'b1;
            m_code  = (code != 0) ? 2'(code) : 2'd2;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                cyc++;
                m_done = 1'b0;
                case (m_phase)
                    0: begin
                        if (start) begin
                            m_phase = 1;
                            m_words.delete();
                            m_err  = 1'b0;
                            m_code = 2'd0;
                        end else if (clear) begin
                            m_cfg = '0;
                        end
                    end
                    1: begin
                        if (start) begin
                            m_words.delete();
                        end else if (cfg_valid) begin
                            m_words.push_back(cfg_data);
                            if (m_words.size() == N + 1) model_judge();
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_ready",   cfg_ready, (m_phase == 1));
            chk("cmp_busy",    busy,      (m_phase == 1));
            chk("cmp_done",    done,      m_done);
            chk("cmp_err",     err,       m_err);
            chk("cmp_errcode", err_code,  m_code);
            chk("cmp_cfg_out", cfg_out,   m_cfg);
            if (done === 1'b1) begin
                done_count++;
                last_done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [CW-1:0] tx [0:N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic send_word(input logic [CW-1:0] w, input int stall_pct);
        int budget;
        int stalls;
        stalls = 0;
        while (stalls < 4 && $urandom_range(0, 99) < stall_pct) begin
            cfg_valid = 1'b0;
            cfg_data  = CW'($urandom);
            step();
            stalls++;
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        budget = 0;
        while (cfg_ready !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        if (cfg_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got cfg_ready=%b expected 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input int stall_pct);
        for (int k = first; k <= last; k++) send_word(tx[k], stall_pct);
    endtask

    task automatic tx_zero();
        for (int k = 0; k <= N; k++) tx[k] = '0;
    endtask

    task automatic tx_checksum();
        logic [CW-1:0] x;
        x = '0;
        for (int k = 0; k < N; k++) x = x ^ tx[k];
        tx[N] = x;
    endtask

    function automatic logic [N*CW-1:0] tx_packed();
        logic [N*CW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*CW +: CW] = tx[k];
        return v;
    endfunction

    function automatic logic [CW-1:0] rand_legal(input int k);
        logic [CW-1:0] w;
        int side;
        int tries;
        w = '0;
        tries = 0;
        do begin
            side = $urandom_range(0, 4);
            w[2:0] = 3'(side);
            w[5:3] = 3'($urandom_range(0, (side == 1 || side == 3) ? NTB - 1 : NLR - 1));
            tries++;
        end while (word_code(w, k) != 0 && tries < 50);
        if (word_code(w, k) != 0) w = '0;
        return w;
    endfunction

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy === 1'b1 && budget < 50) begin
            step();
            budget++;
        end
        step();
        step();
    endtask

    // ---------------- stimulus ----------------
    logic [N*CW-1:0] saved_cfg;
    int start_cyc;
    int dc0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        repeat (3) step();
        chk("rst_cfg_out", cfg_out, 0);
        chk("rst_ready",   cfg_ready, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_done",    done, 0);
        chk("rst_err",     {err, err_code}, 0);
        rst = 1'b0;
        step();

        // cfg_valid while idle must not be consumed.
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_data = CW'($urandom);
            step();
        end
        cfg_valid = 1'b0;

        // Legal frame: top[0] sourced from bottom[1]. Sent back to back.
        tx_zero();
        tx[0] = 6'b001011;
        tx[N] = 6'b001011;
        dc0 = done_count;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        send_range(0, N, 0);
        wait_idle();
        chk("a_latency",    last_done_cyc - start_cyc, 20);
        chk("a_done_count", done_count - dc0, 1);
        chk("a_out_lo",     cfg_out[5:0], 6'b001011);
        chk("a_out_hi",     cfg_out[N*CW-1:6], 0);
        chk("a_err",        err, 0);
        saved_cfg = cfg_out;

        // Same frame with a wrong checksum.
        tx[N] = 6'b000000;
        dc0 = done_count;
        pulse_start();
        send_range(0, N, 0);
        wait_idle();
        chk("b_err",        err, 1);
        chk("b_code",       err_code, 2);
        chk("b_cfg_kept",   cfg_out, saved_cfg);
        chk("b_no_done",    done_count - dc0, 0);

        // left[1] from right index 4: out of range.
        tx_zero();
        tx[2*NTB + 1] = 6'b100010;
        tx_checksum();
        pulse_start();
        send_range(0, N, 20);
        wait_idle();
        chk("c_code",       err_code, 1);
        chk("c_cfg_kept",   cfg_out, saved_cfg);

        // Self-loop at top[2], then an illegal word at right[0]: first wins.
        tx_zero();
        tx[2] = 6'b010001;
        tx[2*NTB + 2*NLR - NLR] = 6'b111001;
        tx_checksum();
        pulse_start();
        send_range(0, N, 20);
        wait_idle();
        chk("d_code",       err_code, 3);
        chk("d_cfg_kept",   cfg_out, saved_cfg);

        // Abort after 7 words, restart, full legal frame with a 3-cycle
        // stall and a clear pulse in the middle.
        for (int k = 0; k < N; k++) tx[k] = rand_legal(k);
        tx_checksum();
        dc0 = done_count;
        pulse_start();
        send_range(0, 6, 0);
        pulse_start();
        send_range(0, 3, 0);
        pulse_clear();
        send_range(4, 8, 0);
        repeat (3) step();
        send_range(9, N, 10);
        wait_idle();
        chk("e_done_count", done_count - dc0, 1);
        chk("e_cfg",        cfg_out, tx_packed());

        // clear in idle zeroes the bus on the next edge.
        pulse_clear();
        chk("f_clear",      cfg_out, 0);

        // Randomized frames: occasional illegal words and bad checksums.
        for (int f = 0; f < 14; f++) begin
            for (int k = 0; k < N; k++) begin
                tx[k] = ($urandom_range(0, 99) < 8) ? CW'($urandom) : rand_legal(k);
            end
            tx_checksum();
            if ($urandom_range(0, 99) < 25) tx[N] = tx[N] ^ CW'($urandom_range(1, 63));
            // start together with clear: start wins.
            if ((f % 4) == 1) clear = 1'b1;
            pulse_start();
            clear = 1'b0;
            if ((f % 5) == 2) begin
                send_range(0, $urandom_range(1, N - 1), 30);
                pulse_start();
            end
            send_range(0, N, 30);
            wait_idle();
            if ((f % 6) == 5) pulse_clear();
        end

        // Make the bus non-zero, then reset in the middle of a frame.
        for (int k = 0; k < N; k++) tx[k] = rand_legal(k);
        tx[0] = 6'b001011;
        tx_checksum();
        pulse_start();
        send_range(0, N, 0);
        wait_idle();
        pulse_start();
        send_range(0, 4, 0);
        rst = 1'b1;
        #1;
        chk("g_rst_cfg_out", cfg_out, 0);
        chk("g_rst_ready",   cfg_ready, 0);
        chk("g_rst_busy",    busy, 0);
        chk("g_rst_flags",   {done, err, err_code}, 0);
        step();
        rst = 1'b0;
        step();

        // Recovery: a legal frame commits after the reset.
        pulse_start();
        send_range(0, N, 15);
        wait_idle();
        chk("h_cfg",         cfg_out, tx_packed());

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
